// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Package : cp0_pkg
// Purpose : Shared types and constants for the CP0 history register file:
//           FSM state encoding and default special-register indices.
// Ports   : n/a (package)
// Rev     : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UNDO = 2'd1,
    ST_EXC  = 2'd2,
    ST_DONE = 2'd3
  } cp0_state_e;

  localparam int unsigned CP0_IDX_STATUS = 12;
  localparam int unsigned CP0_IDX_CAUSE  = 13;
  localparam int unsigned CP0_IDX_EPC    = 14;

endpackage
`default_nettype wire

// File: rtl/cp0_history_rf_if.sv
`default_nettype none
// ============================================================================
// Interface : cp0_history_rf_if
// Purpose   : Bundles the write/read, undo, commit and exception signals of
//             cp0_history_rf.
// Signals   : c0w/waddr/wdata   register write
//             raddr/rdata       combinational read port
//             back/back_cnt     undo request and entry count
//             clear             commit (empty history)
//             exc/wepc/wcause/wstatus  exception entry
//             status/cause/epc  special register views
//             busy/undo_done/hist_cnt  status
// Rev       : 1.0 - initial release
// ============================================================================
interface cp0_history_rf_if #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          c0w;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          back;
  logic [CW-1:0] back_cnt;
  logic          clear;
  logic          exc;
  logic [DW-1:0] wepc;
  logic [DW-1:0] wcause;
  logic [DW-1:0] wstatus;
  logic [DW-1:0] status;
  logic [DW-1:0] cause;
  logic [DW-1:0] epc;
  logic          busy;
  logic          undo_done;
  logic [CW-1:0] hist_cnt;

  modport master (
    output c0w, waddr, wdata, raddr, back, back_cnt, clear,
           exc, wepc, wcause, wstatus,
    input  rdata, status, cause, epc, busy, undo_done, hist_cnt
  );

  modport slave (
    input  c0w, waddr, wdata, raddr, back, back_cnt, clear,
           exc, wepc, wcause, wstatus,
    output rdata, status, cause, epc, busy, undo_done, hist_cnt
  );

endinterface
`default_nettype wire

// File: rtl/cp0_hist_stack.sv
`default_nettype none
// ============================================================================
// Module  : cp0_hist_stack
// Purpose : LIFO of DEPTH entries, W bits wide. Entry 0 is the newest. A push
//           into a full stack drops the oldest entry. clear_i with push_i
//           leaves exactly the pushed entry.
// Ports   : clk, rst (async, active-high)
//           push_i/din_i  push new entry     pop_i   remove newest
//           clear_i       empty the stack    top_o   newest entry
//           cnt_o         number of valid entries
// Rev     : 1.0 - initial release
// ============================================================================
module cp0_hist_stack #(
  parameter int W     = 37,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          push_i,
  input  wire logic          pop_i,
  input  wire logic          clear_i,
  input  wire logic [W-1:0]  din_i,
  output logic      [W-1:0]  top_o,
  output logic      [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      // Shift toward the old end; the last slot falls off when full.
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) mem_q[i] <= mem_q[i-1];
      if (clear_i)            cnt_q <= CW'(1);
      else if (cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end else if (clear_i) begin
      cnt_q <= '0;
    end
  end

  assign top_o = mem_q[0];
  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cp0_history_rf.sv
`default_nettype none
// ============================================================================
// Module  : cp0_history_rf
// Purpose : CP0 register file with an undo history. Every write saves the
//           overwritten value; back rolls back N writes one per cycle; exc
//           rolls back everything and then loads EPC/CAUSE/STATUS.
// Ports   : clk, rst (async, active-high)
//           bus (cp0_history_rf_if.slave) - all functional signals
// Rev     : 1.0 - initial release
// ============================================================================
module cp0_history_rf
  import cp0_pkg::*;
#(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 4,
  parameter int IDX_STATUS = int'(CP0_IDX_STATUS),
  parameter int IDX_CAUSE  = int'(CP0_IDX_CAUSE),
  parameter int IDX_EPC    = int'(CP0_IDX_EPC)
) (
  input wire logic        clk,
  input wire logic        rst,
  cp0_history_rf_if.slave bus
);

  localparam int NREG = 2 ** AW;
  localparam int CW   = $clog2(DEPTH + 1);

  cp0_state_e     state_q, state_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic           pend_q, pend_d;
  logic           busy_q, done_q;
  logic           latch;
  logic [DW-1:0]  lat_epc_q, lat_cause_q, lat_status_q;
  logic [DW-1:0]  regs_q [NREG];

  logic           accept, push, pop, hclr;
  logic [DW+AW-1:0] top;
  logic [CW-1:0]  hcnt;
  logic [DW-1:0]  top_data;
  logic [AW-1:0]  top_addr;

  assign top_data = top[DW+AW-1:AW];
  assign top_addr = top[AW-1:0];

  // c0w/clear only act when nothing higher-priority is taken this cycle.
  assign accept = (state_q == ST_IDLE || state_q == ST_DONE) && !bus.exc && !bus.back;
  assign push   = accept && bus.c0w;
  assign pop    = (state_q == ST_UNDO);
  assign hclr   = (accept && bus.clear) || (state_q == ST_EXC);

  cp0_hist_stack #(.W(DW + AW), .DEPTH(DEPTH), .CW(CW)) u_hist (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (hclr),
    .din_i   ({regs_q[bus.waddr], bus.waddr}),
    .top_o   (top),
    .cnt_o   (hcnt)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pend_d  = pend_q;
    latch   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.exc) begin
          latch   = 1'b1;
          pend_d  = 1'b1;
          rem_d   = hcnt;
          state_d = (hcnt == '0) ? ST_EXC : ST_UNDO;
        end else if (bus.back) begin
          rem_d   = (bus.back_cnt < hcnt) ? bus.back_cnt : hcnt;
          state_d = (rem_d == '0) ? ST_DONE : ST_UNDO;
        end
      end
      ST_UNDO: begin
        if (bus.exc) begin
          // The restore on this edge pops one entry, so what remains is
          // hcnt-1; undoing exactly that leaves the history empty.
          latch   = 1'b1;
          pend_d  = 1'b1;
          rem_d   = hcnt - 1'b1;
          state_d = (rem_d == '0) ? ST_EXC : ST_UNDO;
        end else begin
          rem_d = rem_q - 1'b1;
          if (rem_d == '0) state_d = pend_q ? ST_EXC : ST_DONE;
        end
      end
      ST_EXC: begin
        pend_d  = 1'b0;
        rem_d   = '0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rem_q        <= '0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lat_epc_q    <= '0;
      lat_cause_q  <= '0;
      lat_status_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      busy_q  <= (state_d == ST_UNDO) || (state_d == ST_EXC);
      done_q  <= (state_d == ST_DONE);
      if (latch) begin
        lat_epc_q    <= bus.wepc;
        lat_cause_q  <= bus.wcause;
        lat_status_q <= bus.wstatus;
      end
      if (push) regs_q[bus.waddr] <= bus.wdata;
      if (pop)  regs_q[top_addr]  <= top_data;
      if (state_q == ST_EXC) begin
        regs_q[IDX_EPC]    <= lat_epc_q;
        regs_q[IDX_CAUSE]  <= lat_cause_q;
        regs_q[IDX_STATUS] <= lat_status_q;
      end
    end
  end

  assign bus.rdata     = regs_q[bus.raddr];
  assign bus.status    = regs_q[IDX_STATUS];
  assign bus.cause     = regs_q[IDX_CAUSE];
  assign bus.epc       = regs_q[IDX_EPC];
  assign bus.busy      = busy_q;
  assign bus.undo_done = done_q;
  assign bus.hist_cnt  = hcnt;

endmodule
`default_nettype wire

// File: tb/tb_cp0_history_rf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_cp0_history_rf
// Purpose : Directed self-checking bench for cp0_history_rf (DW=32, AW=5,
//           DEPTH=4) with hand-computed expected values.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_cp0_history_rf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   nb;

  always #50 clk = ~clk;

  cp0_history_rf_if #(.DW(32), .AW(5), .DEPTH(4)) bus ();

  cp0_history_rf #(.DW(32), .AW(5), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.raddr = a;
    #1;
    chk(tag, bus.rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.c0w = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
    bus.c0w = 1'b0;
  endtask

  task automatic do_back(input logic [2:0] n);
    bus.back = 1'b1; bus.back_cnt = n;
    step();
    bus.back = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Counts busy cycles until undo_done, bounded.
  task automatic wait_done(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.undo_done) break;
      if (bus.busy) nbusy++;
      step();
    end
    chk("undo_done_seen", {31'b0, bus.undo_done}, 32'd1);
  endtask

  initial begin
    bus.c0w = 0; bus.waddr = 0; bus.wdata = 0; bus.raddr = 0;
    bus.back = 0; bus.back_cnt = 0; bus.clear = 0; bus.exc = 0;
    bus.wepc = 0; bus.wcause = 0; bus.wstatus = 0;

    // Reset state
    step(); step();
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_done", {31'b0, bus.undo_done}, 0);
    chk("rst_hist", 32'(bus.hist_cnt), 0);
    chk("rst_epc", bus.epc, 0);
    rst = 1'b0;
    step();

    // Two writes to r3, one to r5, undo two
    wr(3, 32'hA); wr(3, 32'hB); wr(5, 32'hC);
    chk("t1_hist3", 32'(bus.hist_cnt), 3);
    chk_reg("t1_r3_pre", 3, 32'hB);
    do_back(2);
    wait_done(nb);
    chk("t1_busy_cycles", 32'(nb), 2);
    chk_reg("t1_r5", 5, 0);
    chk_reg("t1_r3", 3, 32'hA);
    chk("t1_hist", 32'(bus.hist_cnt), 1);
    step();
    chk("t1_done_pulse", {31'b0, bus.undo_done}, 0);

    // Overflow: five writes into a 4-deep history, then clamp test
    do_reset();
    for (int i = 1; i <= 5; i++) wr(1, 32'(i));
    chk("t2_hist_full", 32'(bus.hist_cnt), 4);
    do_back(4);
    wait_done(nb);
    chk("t2_busy4", 32'(nb), 4);
    chk_reg("t2_r1", 1, 1);
    chk("t2_hist0", 32'(bus.hist_cnt), 0);
    wr(1, 32'h9); wr(1, 32'hA);
    do_back(7);
    wait_done(nb);
    chk("t2_clamp_busy", 32'(nb), 2);
    chk_reg("t2_clamp_r1", 1, 1);
    chk("t2_clamp_hist", 32'(bus.hist_cnt), 0);

    // Exception rolls back all writes
    do_reset();
    wr(6, 32'h11); wr(7, 32'h22);
    bus.exc = 1; bus.wepc = 32'h100; bus.wcause = 32'h20; bus.wstatus = 32'h1;
    step();
    bus.exc = 0;
    wait_done(nb);
    chk("t3_busy", 32'(nb), 3);
    chk_reg("t3_r6", 6, 0);
    chk_reg("t3_r7", 7, 0);
    chk("t3_epc", bus.epc, 32'h100);
    chk("t3_cause", bus.cause, 32'h20);
    chk("t3_status", bus.status, 32'h1);
    chk("t3_hist", 32'(bus.hist_cnt), 0);

    // Exceptions arriving during UNDO: second one's values win
    do_reset();
    wr(8, 1); wr(8, 2); wr(9, 3); wr(10, 4);
    do_back(3);          // now in 1st UNDO cycle
    step();              // 2nd UNDO cycle
    bus.exc = 1; bus.wepc = 32'h200; bus.wcause = 32'h30; bus.wstatus = 32'h2;
    step();
    bus.wepc = 32'h300; bus.wcause = 32'h40; bus.wstatus = 32'h4;
    step();
    bus.exc = 0;
    wait_done(nb);
    chk("t4_busy_tail", 32'(nb), 2);
    chk_reg("t4_r8", 8, 0);
    chk_reg("t4_r9", 9, 0);
    chk_reg("t4_r10", 10, 0);
    chk("t4_epc", bus.epc, 32'h300);
    chk("t4_cause", bus.cause, 32'h40);
    chk("t4_status", bus.status, 32'h4);
    chk("t4_hist", 32'(bus.hist_cnt), 0);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.undo_done) nb++;
    end
    chk("t4_single_done", 32'(nb), 0);

    // Reset mid-UNDO takes effect immediately
    do_reset();
    wr(2, 5); wr(3, 6);
    do_back(2);
    chk("t5_busy_pre", {31'b0, bus.busy}, 1);
    #10 rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'b0, bus.busy}, 0);
    chk("t5_rst_hist", 32'(bus.hist_cnt), 0);
    chk_reg("t5_rst_r3", 3, 0);
    step();
    rst = 1'b0;
    step();
    // c0w and clear during busy are ignored
    wr(4, 7); wr(4, 8);
    do_back(2);
    bus.c0w = 1; bus.clear = 1; bus.waddr = 5; bus.wdata = 32'h55;
    step();
    step();
    bus.c0w = 0; bus.clear = 0;
    wait_done(nb);
    chk_reg("t5_r5", 5, 0);
    chk_reg("t5_r4", 4, 0);
    chk("t5_hist", 32'(bus.hist_cnt), 0);

    // clear+c0w together, then back_cnt=0
    do_reset();
    wr(1, 3); wr(2, 4);
    bus.clear = 1; bus.c0w = 1; bus.waddr = 2; bus.wdata = 32'h7;
    step();
    bus.clear = 0; bus.c0w = 0;
    chk("t6_hist1", 32'(bus.hist_cnt), 1);
    chk_reg("t6_r2", 2, 32'h7);
    do_back(0);
    chk("t6_done", {31'b0, bus.undo_done}, 1);
    chk("t6_busy", {31'b0, bus.busy}, 0);
    chk_reg("t6_r2_kept", 2, 32'h7);
    chk("t6_hist_kept", 32'(bus.hist_cnt), 1);
    step();
    chk("t6_done_low", {31'b0, bus.undo_done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
